// File: rtl/d_mem_param.sv
// d_mem_param: byte/half/word data memory with registered loads and an INIT/RUN controller.
// Define D_MEM_PARAM_INIT_CLEAR_EN to zero the memory with a one-word-per-cycle sweep after reset.
module d_mem_param #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [31:0]       read_data,
    output logic              rd_valid,
    output logic              addr_error,
    output logic              ready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = IDX_W + 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] read_data_q, read_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        addr_error_q, addr_error_d;

    logic [31:0] mem_q [DEPTH];

`ifdef D_MEM_PARAM_INIT_CLEAR_EN
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic             clr_en;
`endif

    logic [IDX_W-1:0] word_idx;
    logic             req;
    logic             in_range;
    logic             bad;
    logic             active;
    logic             st_en;
    logic             ld_en;
    logic [3:0]       st_mask;
    logic [31:0]      st_bits;
    logic [31:0]      st_data;
    logic [31:0]      old_word;
    logic [31:0]      merged_word;
    logic [31:0]      shifted;
    logic [31:0]      load_val;

    assign word_idx = address[OFF_W-1:2];
    assign old_word = mem_q[word_idx];

    // Access qualification: alignment, reserved size and range against 4*DEPTH bytes.
    always_comb begin
        req      = memread | memwrite;
        in_range = (address >> OFF_W) == '0;
        bad      = 1'b0;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = address[0];
            2'b10:   bad = address[1:0] != 2'b00;
            default: bad = 1'b1;
        endcase
        bad    = bad | ~in_range;
        active = ready_q & req;
        st_en  = active & ~bad & memwrite;
        ld_en  = active & ~bad & memread;
    end

    // Store lane selection and read-modify-write merge of the addressed word.
    always_comb begin
        st_mask = 4'b1111;
        st_data = write_data;
        case (size)
            2'b00: begin
                st_mask = 4'(4'b0001 << address[1:0]);
                st_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                st_mask = 4'(4'b0011 << address[1:0]);
                st_data = {2{write_data[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = write_data;
            end
        endcase
        st_bits     = {{8{st_mask[3]}}, {8{st_mask[2]}}, {8{st_mask[1]}}, {8{st_mask[0]}}};
        merged_word = (old_word & ~st_bits) | (st_data & st_bits);
    end

    // Load alignment and extension.
    always_comb begin
        shifted  = old_word >> {address[1:0], 3'b000};
        load_val = old_word;
        case (size)
            2'b00:   load_val = load_unsigned ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = load_unsigned ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = old_word;
        endcase
    end

    // Controller next state and registered output values.
    always_comb begin
        state_d      = state_q;
        read_data_d  = read_data_q;
        rd_valid_d   = 1'b0;
        addr_error_d = 1'b0;
`ifdef D_MEM_PARAM_INIT_CLEAR_EN
        sweep_idx_d  = sweep_idx_q;
        clr_en       = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
`ifdef D_MEM_PARAM_INIT_CLEAR_EN
                clr_en      = 1'b1;
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (sweep_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                rd_valid_d   = ld_en;
                addr_error_d = active & bad;
                if (ld_en) begin
                    read_data_d = load_val;
                end
            end
            default: state_d = ST_INIT;
        endcase
        ready_d = state_d == ST_RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            ready_q      <= 1'b0;
            read_data_q  <= 32'h0;
            rd_valid_q   <= 1'b0;
            addr_error_q <= 1'b0;
`ifdef D_MEM_PARAM_INIT_CLEAR_EN
            sweep_idx_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            read_data_q  <= read_data_d;
            rd_valid_q   <= rd_valid_d;
            addr_error_q <= addr_error_d;
`ifdef D_MEM_PARAM_INIT_CLEAR_EN
            sweep_idx_q  <= sweep_idx_d;
`endif
        end
    end

    // Storage has no reset; only the sweep clears it. Read-first: loads use pre-edge contents.
    always_ff @(posedge clk) begin
`ifdef D_MEM_PARAM_INIT_CLEAR_EN
        if (clr_en) begin
            mem_q[sweep_idx_q] <= 32'h0;
        end else if (st_en) begin
            mem_q[word_idx] <= merged_word;
        end
`else
        if (st_en) begin
            mem_q[word_idx] <= merged_word;
        end
`endif
    end

    assign read_data  = read_data_q;
    assign rd_valid   = rd_valid_q;
    assign addr_error = addr_error_q;
    assign ready      = ready_q;

endmodule
